// File: rtl/celcomb_meas_sequencer.sv
// Measurement sequencer for a bank of ring-oscillator counters: clear, gate one chain, settle, capture.
// Optional build macro CELCOMB_SCAN_EN: one start sweeps chains chan_sel .. NUM_CHAINS-1.
module celcomb_meas_sequencer #(
  parameter int NUM_CHAINS    = 4,
  parameter int COUNT_W       = 24,
  parameter int GATE_W        = 16,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  localparam int CH_W         = $clog2(NUM_CHAINS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CH_W-1:0]               chan_sel,
  input  logic [GATE_W-1:0]             gate_cycles,
  input  logic [NUM_CHAINS*COUNT_W-1:0] osc_count,
  output logic [NUM_CHAINS-1:0]         osc_enable,
  output logic                          osc_reset,
  output logic                          busy,
  output logic [COUNT_W-1:0]            result,
  output logic [CH_W-1:0]               result_chan,
  output logic                          result_valid
);

  localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);
  localparam int SETL_W = $clog2(SETTLE_CYCLES + 1);
  localparam int AUX_W  = (CLR_W > SETL_W) ? CLR_W : SETL_W;
  localparam int TMR_W  = (GATE_W > AUX_W) ? GATE_W : AUX_W;

  if (NUM_CHAINS < 2) begin : g_bad_num_chains
    $error("NUM_CHAINS must be at least 2");
  end
  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("CLEAR_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [CH_W-1:0]     ch, ch_nxt;
  logic [GATE_W-1:0]   glen, glen_nxt;
  logic                chan_ok;
  logic                cap_vld_p0;
  logic [COUNT_W-1:0]  sel_count_p0;

  logic [NUM_CHAINS-1:0] osc_enable_d;
  logic                  osc_reset_d;
  logic                  busy_d;
  logic [COUNT_W-1:0]    result_d;
  logic [CH_W-1:0]       result_chan_d;
  logic                  result_valid_d;

  // A zero gate length would never open the gate; it is stretched to one clock.
  function automatic logic [GATE_W-1:0] gate_len(input logic [GATE_W-1:0] g);
    return (g == '0) ? GATE_W'(1) : g;
  endfunction

  assign chan_ok = (int'(chan_sel) < NUM_CHAINS);

  // State register: timer counts down the remaining cycles of the current phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      ch    <= '0;
      glen  <= GATE_W'(1);
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      ch    <= ch_nxt;
      glen  <= glen_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    ch_nxt     = ch;
    glen_nxt   = glen;
    cap_vld_p0 = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort && chan_ok) begin
          state_nxt = S_CLEAR;
          ch_nxt    = chan_sel;
          glen_nxt  = gate_len(gate_cycles);
          timer_nxt = TMR_W'(CLEAR_CYCLES - 1);
        end
      end
      S_CLEAR: begin
        if (timer == '0) begin
          state_nxt = S_GATE;
          timer_nxt = TMR_W'(glen) - TMR_W'(1);
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      S_GATE: begin
        if (timer == '0) begin
          state_nxt = S_SETTLE;
          timer_nxt = TMR_W'(SETTLE_CYCLES - 1);
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      S_SETTLE: begin
        if (timer == '0) begin
          state_nxt = S_CAPTURE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      S_CAPTURE: begin
        cap_vld_p0 = 1'b1;
        state_nxt  = S_IDLE;
`ifdef CELCOMB_SCAN_EN
        if (ch != CH_W'(NUM_CHAINS - 1)) begin
          state_nxt = S_CLEAR;
          ch_nxt    = ch + CH_W'(1);
          timer_nxt = TMR_W'(CLEAR_CYCLES - 1);
        end
`endif
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort wins over everything, including a capture in flight.
    if (abort && (state != S_IDLE)) begin
      state_nxt  = S_IDLE;
      cap_vld_p0 = 1'b0;
    end
  end

  always_comb begin
    sel_count_p0 = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (ch == CH_W'(i)) begin
        sel_count_p0 = osc_count[i*COUNT_W +: COUNT_W];
      end
    end
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_comb begin
    osc_enable_d = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if ((state_nxt == S_GATE) && (ch_nxt == CH_W'(i))) begin
        osc_enable_d[i] = 1'b1;
      end
    end
    osc_reset_d    = (state_nxt == S_CLEAR);
    busy_d         = (state_nxt != S_IDLE);
    result_d       = result;
    result_chan_d  = result_chan;
    result_valid_d = cap_vld_p0;
    if (cap_vld_p0) begin
      result_d      = sel_count_p0;
      result_chan_d = ch;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osc_enable   <= '0;
      osc_reset    <= 1'b1;
      busy         <= 1'b0;
      result       <= '0;
      result_chan  <= '0;
      result_valid <= 1'b0;
    end else begin
      osc_enable   <= osc_enable_d;
      osc_reset    <= osc_reset_d;
      busy         <= busy_d;
      result       <= result_d;
      result_chan  <= result_chan_d;
      result_valid <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_celcomb_meas_sequencer.sv
// Self-checking bench for celcomb_meas_sequencer with behavioural oscillator counters.
module tb_celcomb_meas_sequencer;

  localparam int NC  = 4;
  localparam int CC  = 2;
  localparam int SC  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [1:0]  chan_sel;
  logic [15:0] gate_cycles;
  logic [95:0] osc_count;
  logic [3:0]  osc_enable;
  logic        osc_reset, busy, result_valid;
  logic [23:0] result;
  logic [1:0]  result_chan;

  logic        start3, abort3;
  logic [1:0]  chan3;
  logic [71:0] osc_count3;
  logic [2:0]  osc_enable3;
  logic        osc_reset3, busy3, result_valid3;
  logic [23:0] result3;
  logic [1:0]  result_chan3;

  celcomb_meas_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .chan_sel(chan_sel),
    .gate_cycles(gate_cycles), .osc_count(osc_count), .osc_enable(osc_enable),
    .osc_reset(osc_reset), .busy(busy), .result(result), .result_chan(result_chan),
    .result_valid(result_valid)
  );

  // Three-chain instance: a 2-bit chan_sel of 3 is out of range here.
  celcomb_meas_sequencer #(.NUM_CHAINS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .chan_sel(chan3),
    .gate_cycles(gate_cycles), .osc_count(osc_count3), .osc_enable(osc_enable3),
    .osc_reset(osc_reset3), .busy(busy3), .result(result3), .result_chan(result_chan3),
    .result_valid(result_valid3)
  );

  always #5 clk = ~clk;

  // Behavioural chains: clear to a preset, then count once every div_cfg enabled clocks.
  logic [23:0] cnt [NC];
  logic [23:0] preset [NC];
  int          div_cfg [NC];
  int          ph [NC];

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (osc_reset) begin
        cnt[i] <= preset[i];
        ph[i]  <= 0;
      end else if (osc_enable[i]) begin
        if (ph[i] >= div_cfg[i] - 1) begin
          cnt[i] <= cnt[i] + 24'd1;
          ph[i]  <= 0;
        end else begin
          ph[i] <= ph[i] + 1;
        end
      end
    end
  end

  assign osc_count  = {cnt[3], cnt[2], cnt[1], cnt[0]};
  assign osc_count3 = '0;

  int          passes = 0;
  int          total  = 0;
  int          dut_strobes;
  logic [23:0] m_res;
  logic [1:0]  m_chan;

  typedef struct {
    int          chan;
    int          gate;
    int          div;
    logic [23:0] pre;
    logic [23:0] exp_res;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Expected behaviour is derived from the phase lengths: each chain takes
  // L = CLEAR + G + SETTLE + 1 clocks, a strobe follows each capture.
  task automatic run_txn(input int ch, input int g, input int abort_at, input bit junk, input string tag);
    int m, geff, len, last_n, idx, r, vch;
    logic b, rst_e, v;
    logic [3:0] en_e;
`ifdef CELCOMB_SCAN_EN
    m = NC - ch;
`else
    m = 1;
`endif
    geff   = (g == 0) ? 1 : g;
    len    = CC + geff + SC + 1;
    last_n = (abort_at >= 0) ? abort_at + 1 : m * len;
    dut_strobes = 0;
    start = 1'b1; chan_sel = 2'(ch); gate_cycles = 16'(g); abort = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 0; n <= last_n; n++) begin
      vch = 0;
      if (abort_at >= 0 && n == last_n) begin
        b = 0; rst_e = 0; en_e = '0; v = 0;
      end else if (n == m * len) begin
        b = 0; rst_e = 0; en_e = '0; v = 1; vch = ch + m - 1;
      end else begin
        idx   = n / len;
        r     = n % len;
        b     = 1;
        rst_e = (r < CC);
        en_e  = (r >= CC && r < CC + geff) ? 4'(1 << (ch + idx)) : 4'd0;
        v     = (r == 0 && idx > 0);
        vch   = ch + idx - 1;
      end
      if (v) begin
        m_res  = 24'(32'(preset[vch]) + 32'(geff / div_cfg[vch]));
        m_chan = 2'(vch);
      end
      if (result_valid) dut_strobes++;
      check($sformatf("%s n=%0d {busy,rst,en,vld,res,ch}", tag, n),
            64'({busy, osc_reset, osc_enable, result_valid, result, result_chan}),
            64'({b, rst_e, en_e, v, m_res, m_chan}));
      if (n == last_n) break;
      abort = (n == abort_at);
      if (junk && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        chan_sel = 2'($urandom_range(0, 3));
        gate_cycles = 16'($urandom_range(0, 20));
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic set_chains(input logic [23:0] p, input int d);
    for (int i = 0; i < NC; i++) begin
      preset[i]  = p;
      div_cfg[i] = d;
    end
  endtask

  vec_t vecs[6];

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; chan_sel = '0; gate_cycles = '0;
    start3 = 1'b0; abort3 = 1'b0; chan3 = '0;
    m_res = '0; m_chan = '0;
    set_chains(24'd0, 1);

    vecs[0] = '{chan: 2, gate: 100, div: 3, pre: 24'd0,       exp_res: 24'd33};
    vecs[1] = '{chan: 0, gate: 0,   div: 1, pre: 24'd0,       exp_res: 24'd1};
    vecs[2] = '{chan: 3, gate: 32,  div: 1, pre: 24'hFFFFF0,  exp_res: 24'h000010};
    vecs[3] = '{chan: 1, gate: 7,   div: 2, pre: 24'd100,     exp_res: 24'd103};
    vecs[4] = '{chan: 0, gate: 1,   div: 1, pre: 24'hFFFFFF,  exp_res: 24'h000000};
    vecs[5] = '{chan: 3, gate: 40,  div: 4, pre: 24'h123456,  exp_res: 24'h123460};

    tick(); tick();
    check("reset values", 64'({busy, osc_reset, osc_enable, result_valid, result, result_chan}),
          64'({1'b0, 1'b1, 4'd0, 1'b0, 24'd0, 2'd0}));
    reset = 1'b0;
    #1;
    check("osc_reset before first edge", 64'(osc_reset), 64'(1'b1));
    tick();
    check("idle after release", 64'({busy, osc_reset, osc_enable, result_valid, result, result_chan}),
          64'({1'b0, 1'b0, 4'd0, 1'b0, 24'd0, 2'd0}));

    // Out-of-range channel on the three-chain instance, then an in-range one.
    chan3 = 2'd3; start3 = 1'b1; tick(); start3 = 1'b0;
    check("out-of-range busy", 64'({busy3, osc_enable3}), 64'({1'b0, 3'd0}));
    chan3 = 2'd2; start3 = 1'b1; tick(); start3 = 1'b0;
    check("in-range busy", 64'(busy3), 64'(1'b1));
    abort3 = 1'b1; tick(); abort3 = 1'b0;
    check("abort3 idle", 64'({busy3, result_valid3}), 64'({1'b0, 1'b0}));

    for (int i = 0; i < 6; i++) begin
      set_chains(vecs[i].pre, vecs[i].div);
      run_txn(vecs[i].chan, vecs[i].gate, -1, 1'b0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d result", i), 64'(result), 64'(vecs[i].exp_res));
    end

    set_chains(24'd0, 1);
    run_txn(1, 20, CC + 5, 1'b0, "abort_gate");
    run_txn(2, 10, -1, 1'b1, "start_while_busy");

    // Reset in the middle of a gate clears every output at once.
    start = 1'b1; chan_sel = 2'd0; gate_cycles = 16'd50; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    check("mid-op reset", 64'({busy, osc_reset, osc_enable, result_valid, result, result_chan}),
          64'({1'b0, 1'b1, 4'd0, 1'b0, 24'd0, 2'd0}));
    tick();
    reset = 1'b0;
    tick();
    m_res = '0; m_chan = '0;
    check("idle after mid-op reset", 64'({busy, osc_reset, osc_enable}), 64'({1'b0, 1'b0, 4'd0}));

`ifdef CELCOMB_SCAN_EN
    set_chains(24'd7, 2);
    run_txn(1, 20, -1, 1'b0, "scan");
    check("scan strobe count", 64'(dut_strobes), 64'(3));
`endif

    for (int t = 0; t < 40; t++) begin
      int ch, g, ab, m;
      for (int i = 0; i < NC; i++) begin
        div_cfg[i] = $urandom_range(1, 4);
        preset[i]  = ($urandom_range(0, 1) == 1) ? 24'hFFFFE0 + 24'($urandom_range(0, 31))
                                                  : 24'($urandom);
      end
      ch = $urandom_range(0, 3);
      g  = $urandom_range(0, 30);
`ifdef CELCOMB_SCAN_EN
      m = NC - ch;
`else
      m = 1;
`endif
      ab = ($urandom_range(0, 3) == 0)
           ? $urandom_range(0, m * (CC + ((g == 0) ? 1 : g) + SC + 1) - 1) : -1;
      run_txn(ch, g, ab, 1'b1, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
